// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-memory request path: RAM handshake states,
// arbiter FSM states and request kinds.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    IWORD  = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2
  } req_kind_t;

  localparam logic [31:0] BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises per-CPU icache/dcache requests onto one RAM port and returns
// each result with a one-cycle low pulse on the requester's wait line.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS     = 2,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] BAD_WORD = cpu_types_pkg::BAD_WORD
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [32*CPUS-1:0]   iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [32*CPUS-1:0]   daddr,
  input  logic [32*CPUS-1:0]   dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [32*CPUS-1:0]   iload,
  output logic [CPUS-1:0]      dwait,
  output logic [32*CPUS-1:0]   dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic                 merr
);

  localparam int unsigned IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_t    state;
  req_kind_t     kind;
  req_kind_t     gnt_kind;
  ramstate_t     rs;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] gnt_idx;
  logic [CW-1:0] cnt;
  logic [CPUS-1:0] pending;
  logic [CPUS-1:0] gnt_onehot;
  logic          gnt_valid;
  logic          done;
  logic          failed;
  logic [31:0]   word;

  assign rs = ramstate_t'(ramstate);

  rr_arbiter #(.N(CPUS), .IW(IW)) u_rr (
    .req   (pending),
    .ptr   (ptr),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  // A write wins over a read on the same CPU, so dWEN+dREN is a write.
  always_comb begin
    pending = iREN | dREN | dWEN;
    if (|(dWEN & gnt_onehot))      gnt_kind = DWRITE;
    else if (|(dREN & gnt_onehot)) gnt_kind = DREAD;
    else                           gnt_kind = IWORD;
  end

  // ACCESS on the last allowed cycle still counts as success.
  always_comb begin
    failed = (rs == ERROR) || ((rs != ACCESS) && (cnt == CW'(TIMEOUT - 1)));
    done   = (rs == ACCESS) || failed;
    word   = failed ? BAD_WORD : ramload;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      kind     <= IWORD;
      ptr      <= '0;
      sel      <= '0;
      cnt      <= '0;
      merr     <= 1'b0;
      iwait    <= '1;
      dwait    <= '1;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            sel      <= gnt_idx;
            kind     <= gnt_kind;
            ramaddr  <= (gnt_kind == IWORD) ? iaddr[32*gnt_idx +: 32]
                                            : daddr[32*gnt_idx +: 32];
            ramstore <= dstore[32*gnt_idx +: 32];
            ramREN   <= (gnt_kind != DWRITE);
            ramWEN   <= (gnt_kind == DWRITE);
            state    <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (failed) merr <= 1'b1;
            if (kind == IWORD) begin
              iwait[sel]          <= 1'b0;
              iload[32*sel +: 32] <= word;
            end else begin
              dwait[sel]          <= 1'b0;
              dload[32*sel +: 32] <= word;
            end
            state <= RESP;
          end
        end
        RESP: begin
          iwait <= '1;
          dwait <= '1;
          cnt   <= '0;
          ptr   <= (sel == IW'(CPUS - 1)) ? '0 : sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised bench for cache_mem_arbiter: a transaction-level model predicts
// the round-robin winner, RAM strobe duration, returned word and error flag.
module tb_cache_mem_arbiter;

  localparam int CPUS    = 2;
  localparam int TIMEOUT = 8;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic                CLK = 1'b0;
  logic                RST;
  logic [CPUS-1:0]     iREN, dREN, dWEN;
  logic [32*CPUS-1:0]  iaddr, daddr, dstore;
  logic [CPUS-1:0]     iwait, dwait;
  logic [32*CPUS-1:0]  iload, dload;
  logic                ramREN, ramWEN, merr;
  logic [31:0]         ramaddr, ramstore, ramload;
  logic [1:0]          ramstate;

  int errors = 0;
  int checks = 0;
  int rr_m = 0;
  bit merr_m = 1'b0;
  logic [31:0] mem [logic [31:0]];

  cache_mem_arbiter #(.CPUS(CPUS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A0000);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h200 + 32'($urandom_range(0, 7)) * 4;
  endfunction

  // Entered at a negedge; returns at the negedge of the response cycle.
  // lat = BUSY cycles before the RAM answers; err selects ERROR over ACCESS.
  task automatic run_txn(input int lat, input bit err, input int gap, input bit keep);
    int cpu, kind, c, n, dur;
    bit fail;
    logic [31:0] a, st, rd;
    logic [CPUS-1:0] exp_i, exp_d;
    cpu = -1;
    for (int k = 0; k < CPUS; k++)
      if (cpu < 0 && (iREN[(rr_m+k)%CPUS] || dREN[(rr_m+k)%CPUS] || dWEN[(rr_m+k)%CPUS]))
        cpu = (rr_m + k) % CPUS;
    if (cpu < 0) begin
      check("no_request", 64'(cpu), 0);
      return;
    end
    kind = dWEN[cpu] ? 2 : (dREN[cpu] ? 1 : 0);
    a    = (kind == 0) ? iaddr[cpu*32 +: 32] : daddr[cpu*32 +: 32];
    st   = dstore[cpu*32 +: 32];
    rd   = memval(a);
    fail = (lat >= TIMEOUT) || err;
    dur  = (lat >= TIMEOUT) ? TIMEOUT : lat + 1;

    c = 0;
    do begin
      @(negedge CLK);
      c++;
      if (c == 1) check("wait_idle", {iwait, dwait}, {(2*CPUS){1'b1}});
    end while (!(ramREN || ramWEN) && c < 6);
    check("arb_gap", c, gap);
    if (!(ramREN || ramWEN)) return;

    check("ren", ramREN, kind != 2);
    check("wen", ramWEN, kind == 2);
    check("addr", ramaddr, a);
    if (kind == 2) check("store", ramstore, st);

    n = 0;
    while ((ramREN || ramWEN) && n < TIMEOUT + 4) begin
      if (n == lat) begin
        ramstate = err ? 2'd3 : 2'd2;
        ramload  = (kind == 2) ? $urandom : rd;
        if (!err && kind == 2) mem[a] = st;
      end else begin
        ramstate = 2'd1;
        ramload  = $urandom;
      end
      @(negedge CLK);
      n++;
    end
    ramstate = 2'd0;
    check("strobe_len", n, dur);

    exp_i = '1;
    exp_d = '1;
    if (kind == 0) exp_i[cpu] = 1'b0;
    else           exp_d[cpu] = 1'b0;
    merr_m = merr_m || fail;
    check("iwait", iwait, exp_i);
    check("dwait", dwait, exp_d);
    check("merr", merr, merr_m);
    if (kind == 0) check("iload", iload[cpu*32 +: 32], fail ? BAD : rd);
    else if (kind == 1 || fail) check("dload", dload[cpu*32 +: 32], fail ? BAD : rd);
    rr_m = (cpu + 1) % CPUS;
    if (!keep) begin
      case (kind)
        0:       iREN[cpu] = 1'b0;
        1:       dREN[cpu] = 1'b0;
        default: dWEN[cpu] = 1'b0;
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = 2'd0; ramload = '0;
    repeat (2) @(negedge CLK);
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    check("rst_ren", ramREN, 0);
    check("rst_wen", ramWEN, 0);
    check("rst_addr", ramaddr, 0);
    check("rst_store", ramstore, 0);
    check("rst_merr", merr, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Minimum-latency fetch.
    mem[32'h40] = 32'h8C220004;
    iREN[0] = 1'b1; iaddr[31:0] = 32'h40;
    run_txn(0, 0, 1, 0);

    // Write wins over read and fetch; the rest follow in later transactions.
    dWEN[0] = 1'b1; dREN[0] = 1'b1; iREN[0] = 1'b1;
    daddr[31:0] = 32'h100; dstore[31:0] = 32'hDEADBEEF; iaddr[31:0] = 32'h44;
    run_txn(0, 0, 2, 0);
    run_txn(1, 0, 2, 0);
    run_txn(0, 0, 2, 0);

    // Continuous fetches from both CPUs alternate.
    iREN = 2'b11; iaddr = {32'h1000, 32'h2000};
    for (int t = 0; t < 4; t++) run_txn($urandom_range(0, 2), 0, 2, 1);
    iREN = '0;

    dREN[0] = 1'b1; daddr[31:0] = 32'h300;
    run_txn(5, 0, 2, 0);
    dREN[1] = 1'b1; daddr[63:32] = 32'h304;
    run_txn(20, 0, 2, 0);
    dREN[0] = 1'b1; daddr[31:0] = 32'h308;
    run_txn(0, 1, 2, 0);
    iREN[1] = 1'b1; iaddr[63:32] = 32'h48;
    run_txn(1, 0, 2, 0);
    dREN[1] = 1'b1; daddr[63:32] = 32'h30C;
    run_txn(TIMEOUT - 1, 0, 2, 0);

    // Asynchronous reset while a write is in flight.
    dWEN[0] = 1'b1; daddr[31:0] = 32'h400; dstore[31:0] = $urandom;
    repeat (2) @(negedge CLK);
    check("pre_rst_wen", ramWEN, 1);
    ramstate = 2'd1;
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("arst_ren", ramREN, 0);
    check("arst_wen", ramWEN, 0);
    check("arst_waits", {iwait, dwait}, 4'hF);
    check("arst_iload", iload, 0);
    check("arst_merr", merr, 0);
    merr_m = 1'b0;
    rr_m = 0;
    ramstate = 2'd0;
    @(negedge CLK);
    RST = 1'b0;
    iREN[1] = 1'b1; iaddr[63:32] = 32'h50;
    run_txn(0, 0, 1, 0);

    for (int t = 0; t < 40; t++) begin
      for (int q = 0; q < CPUS; q++) begin
        if (!iREN[q] && $urandom_range(0, 1) == 1) begin
          iREN[q] = 1'b1;
          iaddr[q*32 +: 32] = rand_addr();
        end
        if (!dREN[q] && !dWEN[q] && $urandom_range(0, 1) == 1) begin
          daddr[q*32 +: 32]  = rand_addr();
          dstore[q*32 +: 32] = $urandom;
          case ($urandom_range(0, 2))
            0:       dREN[q] = 1'b1;
            1:       dWEN[q] = 1'b1;
            default: begin dREN[q] = 1'b1; dWEN[q] = 1'b1; end
          endcase
        end
      end
      if (!(|iREN) && !(|dREN) && !(|dWEN)) begin
        iREN[0] = 1'b1;
        iaddr[31:0] = rand_addr();
      end
      run_txn($urandom_range(0, 9), $urandom_range(0, 9) == 0, 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
